// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the multiply/divide scheduler.
// Holds op and state encodings, the divide-by-zero quotient and the cache entry layout.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMul   = 3'd0,
        OpMulh  = 3'd1,
        OpMulhu = 3'd2,
        OpDiv   = 3'd3,
        OpMod   = 3'd4,
        OpDivu  = 3'd5,
        OpModu  = 3'd6
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StDivStart,
        StDivWait,
        StRsp
    } state_e;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] src1;
        logic [31:0] src2;
        logic        sign;
        logic [31:0] quo;
        logic [31:0] rem;
    } div_entry_t;

    function automatic logic op_is_mul(op_e op);
        return op inside {OpMul, OpMulh, OpMulhu};
    endfunction

    function automatic logic op_signed(op_e op);
        return op inside {OpMul, OpMulh, OpDiv, OpMod};
    endfunction

    function automatic logic op_is_rem(op_e op);
        return op inside {OpMod, OpModu};
    endfunction

endpackage

// File: rtl/muldiv_hist_cache.sv
// Two-entry history of completed divides, looked up combinationally.
// Entries are replaced alternately; valid bits clear only on reset.
module muldiv_hist_cache
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lk_src1,
    input  logic [31:0] lk_src2,
    input  logic        lk_sign,
    output logic        hit,
    output logic [31:0] hit_quo,
    output logic [31:0] hit_rem,
    input  logic        wr_en,
    input  div_entry_t  wr_entry
);

    div_entry_t entry_q [2];
    logic [1:0] valid_q;
    logic       ptr_q;

    always_comb begin
        hit     = 1'b0;
        hit_quo = '0;
        hit_rem = '0;
        for (int i = 0; i < 2; i++) begin
            if (valid_q[i] && entry_q[i].src1 == lk_src1 && entry_q[i].src2 == lk_src2 &&
                entry_q[i].sign == lk_sign) begin
                hit     = 1'b1;
                hit_quo = entry_q[i].quo;
                hit_rem = entry_q[i].rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 2'b00;
            ptr_q   <= 1'b0;
        end else if (wr_en) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= ~ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            entry_q[ptr_q] <= wr_entry;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// Two-port scheduler in front of the shared multiplier and SRT divider cores.
// Trivial and repeated divides answer one cycle after accept without starting the divider.
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][2:0]       req_op,
    input  logic [1:0][31:0]      req_src1,
    input  logic [1:0][31:0]      req_src2,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic [31:0]           mul_op1,
    output logic [31:0]           mul_op2,
    output logic                  mul_sign,
    input  logic [63:0]           mul_result,
    output logic                  div_en,
    output logic                  div_sign,
    output logic [31:0]           div_op1,
    output logic [31:0]           div_op2,
    input  logic [31:0]           div_quo,
    input  logic [31:0]           div_rem,
    input  logic                  div_ready,
    input  logic                  div_complete,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_port,
    output logic [TAG_W-1:0]      rsp_tag,
    output logic [31:0]           rsp_result
);

    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_e            state_q;
    op_e               op_q;
    logic [31:0]       src1_q, src2_q, result_q;
    logic              port_q, last_q, div_en_q;
    logic [TAG_W-1:0]  tag_q;
    logic [CntW-1:0]   cnt_q;

    logic        sel, accept, short_hit, c_hit, cache_we, div_busy;
    op_e         a_op;
    logic [31:0] a_src1, a_src2, short_quo, short_rem, c_quo, c_rem;

    // last_q holds the port granted most recently; on a tie the other port wins.
    always_comb begin
        case (req_valid)
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_q;
            default: sel = 1'b0;
        endcase
    end

    assign accept    = (state_q == StIdle) && !flush && !rst && (req_valid != 2'b00);
    assign req_ready = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;
    assign a_op      = op_e'(req_op[sel]);
    assign a_src1    = req_src1[sel];
    assign a_src2    = req_src2[sel];

    muldiv_hist_cache u_cache (
        .clk      (clk),
        .rst      (rst),
        .lk_src1  (a_src1),
        .lk_src2  (a_src2),
        .lk_sign  (op_signed(a_op)),
        .hit      (c_hit),
        .hit_quo  (c_quo),
        .hit_rem  (c_rem),
        .wr_en    (cache_we),
        .wr_entry ('{src1: src1_q, src2: src2_q, sign: op_signed(op_q),
                     quo: div_quo, rem: div_rem})
    );

    always_comb begin
        short_hit = 1'b1;
        short_quo = '0;
        short_rem = '0;
        if (a_src2 == '0) begin
            short_quo = DIV0_QUO;
            short_rem = a_src1;
        end else if (a_src1 == '0) begin
            short_hit = 1'b1;
        end else if (c_hit) begin
            short_quo = c_quo;
            short_rem = c_rem;
        end else begin
            short_hit = 1'b0;
        end
    end

    assign cache_we = (state_q == StDivWait) && div_complete && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            port_q   <= 1'b0;
            last_q   <= 1'b1;
            tag_q    <= '0;
            cnt_q    <= '0;
            div_en_q <= 1'b0;
        end else begin
            div_en_q <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept) begin
                            last_q <= sel;
                            port_q <= sel;
                            op_q   <= a_op;
                            src1_q <= a_src1;
                            src2_q <= a_src2;
                            tag_q  <= req_tag[sel];
                            cnt_q  <= '0;
                            if (op_is_mul(a_op)) begin
                                state_q <= StMul;
                            end else if (short_hit) begin
                                result_q <= op_is_rem(a_op) ? short_rem : short_quo;
                                state_q  <= StRsp;
                            end else begin
                                state_q <= StDivStart;
                            end
                        end
                    end
                    StMul: begin
                        if (cnt_q == CntW'(MUL_LAT - 1)) begin
                            result_q <= (op_q == OpMul) ? mul_result[31:0] : mul_result[63:32];
                            state_q  <= StRsp;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StDivStart: begin
                        if (div_ready) begin
                            div_en_q <= 1'b1;
                            state_q  <= StDivWait;
                        end
                    end
                    StDivWait: begin
                        if (div_complete) begin
                            result_q <= op_is_rem(op_q) ? div_rem : div_quo;
                            state_q  <= StRsp;
                        end
                    end
                    StRsp: begin
                        if (rsp_ready) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign div_busy   = (state_q == StDivStart) || (state_q == StDivWait);
    assign mul_op1    = (state_q == StMul) ? src1_q : '0;
    assign mul_op2    = (state_q == StMul) ? src2_q : '0;
    assign mul_sign   = (state_q == StMul) && op_signed(op_q);
    assign div_en     = div_en_q;
    assign div_sign   = div_busy && op_signed(op_q);
    assign div_op1    = div_busy ? src1_q : '0;
    assign div_op2    = div_busy ? src2_q : '0;
    assign rsp_valid  = (state_q == StRsp);
    assign rsp_port   = port_q;
    assign rsp_tag    = tag_q;
    assign rsp_result = result_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched with behavioural multiplier and 34-cycle divider models.
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int unsigned TAG_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  flush = 1'b0;
    logic [1:0]            req_valid = '0;
    logic [1:0]            req_ready;
    logic [1:0][2:0]       req_op = '0;
    logic [1:0][31:0]      req_src1 = '0;
    logic [1:0][31:0]      req_src2 = '0;
    logic [1:0][TAG_W-1:0] req_tag = '0;
    logic [31:0]           mul_op1, mul_op2;
    logic                  mul_sign;
    logic [63:0]           mul_result = '0;
    logic                  div_en, div_sign;
    logic [31:0]           div_op1, div_op2;
    logic [31:0]           div_quo = '0;
    logic [31:0]           div_rem = '0;
    logic                  div_ready;
    logic                  div_complete = 1'b0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic                  rsp_port;
    logic [TAG_W-1:0]      rsp_tag;
    logic [31:0]           rsp_result;

    muldiv_sched #(.TAG_W(TAG_W), .MUL_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_tag      (req_tag),
        .mul_op1      (mul_op1),
        .mul_op2      (mul_op2),
        .mul_sign     (mul_sign),
        .mul_result   (mul_result),
        .div_en       (div_en),
        .div_sign     (div_sign),
        .div_op1      (div_op1),
        .div_op2      (div_op2),
        .div_quo      (div_quo),
        .div_rem      (div_rem),
        .div_ready    (div_ready),
        .div_complete (div_complete),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_port     (rsp_port),
        .rsp_tag      (rsp_tag),
        .rsp_result   (rsp_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One register stage: operands held in MUL for two cycles give the product at the sample edge.
    always @(posedge clk) begin
        if (mul_sign) mul_result <= {{32{mul_op1[31]}}, mul_op1} * {{32{mul_op2[31]}}, mul_op2};
        else          mul_result <= {32'b0, mul_op1} * {32'b0, mul_op2};
    end

    int          dv_cnt = 0;
    logic [31:0] dv_a = '0, dv_b = '0;
    logic        dv_s = 1'b0;
    assign div_ready = (dv_cnt == 0);

    always @(posedge clk) begin
        div_complete <= 1'b0;
        if (rst) begin
            dv_cnt <= 0;
        end else if (dv_cnt != 0) begin
            dv_cnt <= dv_cnt - 1;
            if (dv_cnt == 1) begin
                div_complete <= 1'b1;
                if (dv_s) begin
                    div_quo <= $signed(dv_a) / $signed(dv_b);
                    div_rem <= $signed(dv_a) % $signed(dv_b);
                end else begin
                    div_quo <= dv_a / dv_b;
                    div_rem <= dv_a % dv_b;
                end
            end
        end else if (div_en) begin
            dv_a   <= div_op1;
            dv_b   <= div_op2;
            dv_s   <= div_sign;
            dv_cnt <= 34;
        end
    end

    typedef struct {
        logic             port;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        int               cyc;
        int               lat;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          div_en_cnt = 0;
    logic [31:0] exp_res [2];
    int          exp_lat [2];
    bit          exp_push [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every response handshake; also polices divider start timing.
    always @(negedge clk) begin
        if (div_en) begin
            div_en_cnt++;
            check("div_en_while_divider_busy", dv_cnt, 0);
        end
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_with_empty_scoreboard", rsp_valid, 0);
            end else if (rsp_ready) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_result", rsp_result, e.res);
                check("rsp_port", rsp_port, e.port);
                check("rsp_tag", rsp_tag, e.tag);
                if (e.lat != 0) check("rsp_latency", cyc - e.cyc, e.lat);
            end
        end
    end

    task automatic set_req(input int p, input op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag, input logic [31:0] res, input int lat,
                           input bit push);
        req_op[p]   = op;
        req_src1[p] = a;
        req_src2[p] = b;
        req_tag[p]  = tag;
        exp_res[p]  = res;
        exp_lat[p]  = lat;
        exp_push[p] = push;
    endtask

    task automatic wait_grants(input int n);
        int got = 0;
        int guard = 0;
        while (got < n && guard < 500) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                int p = req_ready[1] ? 1 : 0;
                grant_log.push_back(p);
                if (exp_push[p]) sb.push_back('{port: p[0], tag: req_tag[p], res: exp_res[p],
                                               cyc: cyc, lat: exp_lat[p]});
                got++;
            end
            guard++;
        end
        if (got < n) check("grant_timeout", got, n);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int p);
        req_valid = (p == 1) ? 2'b10 : 2'b01;
        wait_grants(1);
        req_valid = 2'b00;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || rsp_valid) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mul_ops"}, {mul_op1, mul_op2}, 64'd0);
        check({tag, "_div_ops"}, {div_op1, div_op2}, 64'd0);
        check({tag, "_ctl"}, {req_ready, mul_sign, div_en, div_sign, rsp_valid, rsp_port, rsp_tag},
              0);
        check({tag, "_rsp_result"}, rsp_result, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int de0;
        int guard;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1;

        // Both ports valid from reset: grants must alternate starting at port 0.
        set_req(0, OpMul,   32'h3, 32'hFFFF_FFFE, 4'h1, 32'hFFFF_FFFA, 3, 1'b1);
        set_req(1, OpMulhu, 32'h3, 32'hFFFF_FFFE, 4'h2, 32'h0000_0002, 3, 1'b1);
        req_valid = 2'b11;
        wait_grants(4);
        req_valid = 2'b00;
        drain();
        for (int i = 0; i < 4; i++) begin
            if (grant_log.size() > i) check($sformatf("alt_grant_%0d", i), grant_log[i], i % 2);
        end

        set_req(0, OpMulh, 32'h3, 32'hFFFF_FFFE, 4'h3, 32'hFFFF_FFFF, 3, 1'b1);
        issue(0);
        drain();

        // Sole requester on port 1, then a tie must go to port 0.
        grant_log.delete();
        set_req(1, OpMul, 32'd7, 32'd6, 4'h4, 32'd42, 3, 1'b1);
        set_req(0, OpMul, 32'd9, 32'd9, 4'h5, 32'd81, 3, 1'b1);
        req_valid = 2'b10;
        wait_grants(1);
        req_valid = 2'b00;
        drain();
        req_valid = 2'b11;
        wait_grants(1);
        req_valid = 2'b00;
        drain();
        if (grant_log.size() == 2) begin
            check("solo_port1_grant", grant_log[0], 1);
            check("tie_after_port1_grant", grant_log[1], 0);
        end else begin
            check("arb_grant_count", grant_log.size(), 2);
        end

        // Full divide, then cache hit on the remainder, then signed miss.
        de0 = div_en_cnt;
        set_req(0, OpDivu, 32'd100, 32'd7, 4'h6, 32'd14, 0, 1'b1);
        issue(0);
        drain();
        check("divu_div_en_pulses", div_en_cnt - de0, 1);

        de0 = div_en_cnt;
        set_req(1, OpModu, 32'd100, 32'd7, 4'h7, 32'd2, 1, 1'b1);
        issue(1);
        drain();
        check("modu_cache_hit_div_en", div_en_cnt - de0, 0);

        de0 = div_en_cnt;
        set_req(0, OpDiv, 32'd100, 32'd7, 4'h8, 32'd14, 0, 1'b1);
        issue(0);
        drain();
        check("signed_div_miss_div_en", div_en_cnt - de0, 1);

        // Trivial divides answer one cycle after accept without the divider.
        de0 = div_en_cnt;
        set_req(0, OpDivu, 32'd5, 32'd0, 4'h9, 32'hFFFF_FFFF, 1, 1'b1);
        issue(0);
        drain();
        set_req(1, OpMod, 32'h1234, 32'd0, 4'hA, 32'h1234, 1, 1'b1);
        issue(1);
        drain();
        set_req(0, OpDiv, 32'd0, 32'd5, 4'hB, 32'd0, 1, 1'b1);
        issue(0);
        drain();
        check("shortcut_div_en", div_en_cnt - de0, 0);

        // Response backpressure with a competing request pending.
        rsp_ready = 1'b0;
        set_req(1, OpMulhu, 32'h3, 32'hFFFF_FFFE, 4'hC, 32'h2, 0, 1'b1);
        issue(1);
        set_req(0, OpMul, 32'd5, 32'd5, 4'hD, 32'd25, 0, 1'b1);
        req_valid = 2'b01;
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_%0d_valid", i), rsp_valid, 1);
            check($sformatf("stall_%0d_result", i), rsp_result, 32'h2);
            check($sformatf("stall_%0d_tag", i), rsp_tag, 4'hC);
            check($sformatf("stall_%0d_req_ready", i), req_ready, 0);
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grants(1);
        req_valid = 2'b00;
        drain();

        // Flush while the divider runs; the op must vanish and leave no cache entry.
        set_req(0, OpDivu, 32'd200, 32'd9, 4'hE, 32'd22, 0, 1'b0);
        issue(0);
        guard = 0;
        while (!div_en && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        set_req(1, OpMul, 32'd2, 32'd2, 4'hF, 32'd4, 0, 1'b0);
        req_valid = 2'b10;
        flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_accept", req_ready, 0);
        @(posedge clk);
        #1 flush = 1'b0;
        req_valid = 2'b00;

        de0 = div_en_cnt;
        set_req(0, OpModu, 32'd200, 32'd9, 4'h1, 32'd2, 0, 1'b1);
        issue(0);
        drain();
        check("post_flush_cache_miss", div_en_cnt - de0, 1);

        // Reset in the middle of a multiply.
        set_req(0, OpMul, 32'h11, 32'h22, 4'h2, 32'h242, 0, 1'b0);
        issue(0);
        rst = 1'b1;
        @(negedge clk);
        check("mul_op1_in_flight", mul_op1, 32'h11);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("midop_reset");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
